// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: syncs, filters and decodes 11-bit frames into scancodes.
// Optional PS2_BREAK_FILTER_EN suppresses break (F0 xx) sequences.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_q;
  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    byte_q;
  logic          par_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    out_q;
  logic          key_q;
  logic          err_q;
`ifdef PS2_BREAK_FILTER_EN
  logic          brk_q;
`endif

  // Two-flop synchronizers for both device lines, idling high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter on the clock line plus registered falling-edge pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FLAST) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
        fall_q <= filt_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // Frame FSM with inter-edge timeout and registered strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      byte_q   <= '0;
      par_q    <= 1'b0;
      timer_q  <= '0;
      out_q    <= '0;
      key_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q    <= 1'b0;
`endif
    end else begin
      key_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        timer_q  <= '0;
        bitcnt_q <= '0;
        if (fall_q && !dat_s2_q) begin
          state_q <= S_DATA;
        end
      end else if (fall_q) begin
        timer_q <= '0;
        case (state_q)
          S_DATA: begin
            byte_q[bitcnt_q] <= dat_s2_q;
            if (bitcnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end else begin
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            if (dat_s2_q && (^{byte_q, par_q})) begin
`ifdef PS2_BREAK_FILTER_EN
              if (brk_q) begin
                brk_q <= 1'b0;
              end else if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
              end else begin
                out_q <= byte_q;
                key_q <= 1'b1;
              end
`else
              out_q <= byte_q;
              key_q <= 1'b1;
`endif
            end else begin
              err_q <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              brk_q <= 1'b0;
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (timer_q == TMAX) begin
        state_q  <= S_IDLE;
        bitcnt_q <= '0;
        timer_q  <= '0;
        err_q    <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        brk_q    <= 1'b0;
`endif
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign ps2_out         = out_q;
  assign ps2_key_pressed = key_q;
  assign frame_error     = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed + randomized bench for ps2_key_receiver against a frame-level model.
// Honors PS2_BREAK_FILTER_EN in the model.
module tb_ps2_key_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_out;
  logic       ps2_key_pressed;
  logic       frame_error;

  int checks   = 0;
  int failures = 0;

  ps2_key_receiver #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .ps2_out        (ps2_out),
    .ps2_key_pressed(ps2_key_pressed),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  int cyc_n = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  logic [7:0] got_q[$];
  int err_cnt  = 0;
  int both_cnt = 0;
  int err_cycle = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (ps2_key_pressed) got_q.push_back(ps2_out);
      if (frame_error) begin
        err_cnt++;
        err_cycle = cyc_n;
      end
      if (ps2_key_pressed && frame_error) both_cnt++;
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] exp_out = 8'h00;
  int exp_err = 0;
`ifdef PS2_BREAK_FILTER_EN
  bit brk_m = 0;
`endif
  int last_fall = 0;

  task automatic model_valid(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (brk_m) brk_m = 0;
    else if (b == 8'hF0) brk_m = 1;
    else begin
      exp_q.push_back(b);
      exp_out = b;
    end
`else
    exp_q.push_back(b);
    exp_out = b;
`endif
  endtask

  task automatic model_error();
    exp_err++;
`ifdef PS2_BREAK_FILTER_EN
    brk_m = 0;
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(20);
    ps2_clk = 1'b0;
    last_fall = cyc_n;
    cyc(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_bad,
                            input bit stop);
    logic p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    p = (~^d) ^ par_bad;
    send_bit(p);
    send_bit(stop);
    ps2_data = 1'b1;
    cyc(20);
    if (!par_bad && stop) model_valid(d);
    else model_error();
  endtask

  task automatic check_state(input string tag);
    checks++;
    assert (got_q.size() == exp_q.size()) else begin
      failures++;
      $error("FAIL %s strobes got=%0d exp=%0d", tag, got_q.size(),
             exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      assert (i < got_q.size() && got_q[i] === exp_q[i]) else begin
        failures++;
        $error("FAIL %s byte%0d got=%h exp=%h", tag, i,
               (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    assert (ps2_out === exp_out) else begin
      failures++;
      $error("FAIL %s ps2_out got=%h exp=%h", tag, ps2_out, exp_out);
    end
    checks++;
    assert (err_cnt == exp_err) else begin
      failures++;
      $error("FAIL %s errors got=%0d exp=%0d", tag, err_cnt, exp_err);
    end
    checks++;
    assert (both_cnt == 0) else begin
      failures++;
      $error("FAIL %s overlap got=%0d exp=0", tag, both_cnt);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    checks++;
    assert (ps2_out === 8'h00 && ps2_key_pressed === 1'b0 &&
            frame_error === 1'b0) else begin
      failures++;
      $error("FAIL %s outs got=%h/%b/%b exp=00/0/0", tag, ps2_out,
             ps2_key_pressed, frame_error);
    end
  endtask

  initial begin
    int dly;
    logic [7:0] rb;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    check_idle_outs("reset");
    reset = 1'b0;
    cyc(10);
    check_state("post_reset");

    send_frame(8'h1C, 1'b0, 1'b1);
    check_state("t1_valid_1c");

    send_frame(8'h1C, 1'b1, 1'b1);
    check_state("t2_parity_err");

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    cyc(2);
    ps2_clk  = 1'b1;
    cyc(30);
    ps2_data = 1'b1;
    cyc(10);
    check_state("t3_glitch");
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("t3_frame_29");

    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    cyc(250);
    model_error();
    check_state("t4_timeout");
    dly = err_cycle - last_fall;
    checks++;
    assert (dly >= 200 && dly <= 216) else begin
      failures++;
      $error("FAIL t4_timeout_delay got=%0d exp=200..216", dly);
    end
    send_frame(8'h32, 1'b0, 1'b1);
    check_state("t4_frame_32");

    send_bit(1'b0);
    rb = 8'h45;
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    ps2_data = rb[4];
    cyc(10);
    reset = 1'b1;
    cyc(3);
    check_idle_outs("t5_in_reset");
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(5);
    check_idle_outs("t5_in_reset2");
    reset = 1'b0;
    exp_out = 8'h00;
`ifdef PS2_BREAK_FILTER_EN
    brk_m = 0;
`endif
    cyc(60);
    check_state("t5_release");
    send_frame(8'h16, 1'b0, 1'b1);
    check_state("t5_frame_16");

    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b1);
    check_state("t6_break_seq");

    send_frame(8'h5A, 1'b0, 1'b0);
    check_state("stop_err");

    for (int k = 0; k < 12; k++) begin
      bit pb;
      bit sb;
      rb = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      pb = ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 5) != 0);
      send_frame(rb, pb, sb);
      check_state($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
